lna_bias_sequencer: RTL and testbench
=====================================

// Module: lna_bias_sequencer
// PURPOSE
//  Sequences the LNA's V- and V+ supplies: power-up sets V- (gate) first, then V+ (drain).
//  Power-down runs in reverse order. Supervises the power-good inputs, enforces ramp
//  timeouts and latches faults. Sits in the link power top, clocked from the 100 MHz
//  crystal-derived clock, and drives the enables of the V+/V- generator.
// PARAMETERS
//  TIMER_WIDTH      20      width of the shared cycle timer
//  RAMP_TIMEOUT     100000  cycles allowed for a rail to report good (1 ms @ 100 MHz)
//  SETTLE_CYCLES    10000   dwell after V- good before V+ is enabled
//  OFF_DELAY_CYCLES 5000    dwell after each rail disable during shutdown
// PORTS
//  Clock100Mhz   in   1  system clock, all logic on rising edge
//  ResetN        in   1  synchronous, active-low reset
//  PowerRequest  in   1  level: 1 = LNA powered wanted
//  FaultClear    in   1  pulse: clears a latched fault (only acted on with PowerRequest=0)
//  VminusGood    in   1  async power-good of V- rail
//  VplusGood     in   1  async power-good of V+ rail
//  EnableVminus  out  1  enable to V- generator
//  EnableVplus   out  1  enable to V+ generator
//  LnaReady      out  1  both rails up and settled
//  Fault         out  1  latched fault flag
//  FaultCode     out  3  0 none, 1 V- timeout, 2 V+ timeout, 3 V- lost, 4 V+ lost
//  SeqState      out  3  current state encoding (debug)
// BEHAVIOUR
//  Reset: all outputs 0, state OFF, timer 0, synchronizer flops 0. Reset mid-sequence drops both enables on the next edge.
//  VminusGood/VplusGood pass through 2-flop synchronizers (2-cycle latency). All rules use the synced values.
//  All outputs are registered and reflect the state entered on the same edge.
//  Timer clears on every state change and increments otherwise. It saturates at all-ones.
//  A state's wait "expires" when timer == PARAM-1.
//  States / encoding:
//   OFF(0): enables 0. PowerRequest=1 && !Fault -> NEG_ON.
//   NEG_ON(1): EnableVminus=1. Vminus good -> NEG_SETTLE. Else expiry of RAMP_TIMEOUT -> FAULT, code 1.
//     PowerRequest=0 -> NEG_OFF.
//   NEG_SETTLE(2): EnableVminus=1. Vminus not good -> FAULT, code 3.
//     SETTLE_CYCLES expiry -> POS_ON. PowerRequest=0 -> NEG_OFF.
//   POS_ON(3): both enables 1. Vminus loss -> FAULT, code 3. Vplus good -> ON.
//     Else RAMP_TIMEOUT expiry -> FAULT, code 2. PowerRequest=0 -> POS_OFF.
//   ON(4): both enables 1, LnaReady=1. Vminus loss -> FAULT, code 3. Vplus loss -> FAULT, code 4.
//     PowerRequest=0 -> POS_OFF.
//   POS_OFF(5): EnableVplus=0, EnableVminus=1. OFF_DELAY_CYCLES expiry -> NEG_OFF.
//   NEG_OFF(6): both enables 0. OFF_DELAY_CYCLES expiry -> OFF.
//   FAULT(7): EnableVplus=0, LnaReady=0, Fault=1.
//     EnableVminus stays 1 for OFF_DELAY_CYCLES, then 0. This keeps the gate biased while drain discharges.
//     After the delay: FaultClear=1 && PowerRequest=0 -> OFF, with Fault=0 and FaultCode=0.
//     FaultClear is ignored before the delay ends or while PowerRequest=1.
//  Priority in a cycle: V- fault > V+ fault > timeout > PowerRequest drop > normal advance.
//  Both rails lost in the same cycle -> code 3.
//  FaultCode is written only on entry to FAULT and holds until cleared.
//  PowerRequest reasserted during POS_OFF/NEG_OFF: the shutdown completes to OFF first, then restarts.
//  Good inputs are ignored in OFF, POS_OFF and NEG_OFF (no faults raised there).
// TESTING (bench params: RAMP_TIMEOUT=20, SETTLE_CYCLES=8, OFF_DELAY_CYCLES=4)
//  1 Normal up/down: PowerRequest=1, V- good at cycle 5, V+ good 3 cycles after EnableVplus.
//    -> EnableVminus before EnableVplus by >=8 cycles; LnaReady=1.
//    Then PowerRequest=0 -> EnableVplus low, EnableVminus low 4 cycles later, then OFF.
//  2 V- timeout: PowerRequest=1, VminusGood held 0.
//    -> FAULT with FaultCode=1 exactly 20 cycles after NEG_ON entry.
//    EnableVminus falls 4 cycles later. EnableVplus never asserted.
//  3 V+ timeout: V- good, V+ never good.
//    -> FaultCode=2 after 20 cycles in POS_ON; EnableVplus=0 on FAULT entry.
//  4 Rail loss in ON: drop VplusGood -> FaultCode=4 within 3 cycles (sync + 1).
//    Repeat dropping both rails same cycle -> FaultCode=3.
//  5 Fault clear gating: FaultClear with PowerRequest=1 -> stays FAULT.
//    PowerRequest=0 + FaultClear after the delay -> OFF, Fault=0, FaultCode=0.
//  6 Mid-sequence abort/reset: PowerRequest=0 in POS_ON -> POS_OFF -> NEG_OFF -> OFF.
//    ResetN=0 in ON -> both enables 0 next edge, SeqState=0.

Source files
------------

// File: rtl/lna_bias_sequencer.sv
// LNA bias sequencer: brings V- (gate) up before V+ (drain), tears down in reverse,
// supervises both power-good inputs and latches the first fault seen.
module lna_bias_sequencer #(
  parameter int TIMER_WIDTH      = 20,
  parameter int RAMP_TIMEOUT     = 100000,
  parameter int SETTLE_CYCLES    = 10000,
  parameter int OFF_DELAY_CYCLES = 5000
) (
  input  logic       Clock100Mhz,
  input  logic       ResetN,
  input  logic       PowerRequest,
  input  logic       FaultClear,
  input  logic       VminusGood,
  input  logic       VplusGood,
  output logic       EnableVminus,
  output logic       EnableVplus,
  output logic       LnaReady,
  output logic       Fault,
  output logic [2:0] FaultCode,
  output logic [2:0] SeqState
);

  typedef enum logic [2:0] {
    ST_OFF        = 3'd0,
    ST_NEG_ON     = 3'd1,
    ST_NEG_SETTLE = 3'd2,
    ST_POS_ON     = 3'd3,
    ST_ON         = 3'd4,
    ST_POS_OFF    = 3'd5,
    ST_NEG_OFF    = 3'd6,
    ST_FAULT      = 3'd7
  } state_t;

  localparam logic [TIMER_WIDTH-1:0] RAMP_LAST   = TIMER_WIDTH'(RAMP_TIMEOUT - 1);
  localparam logic [TIMER_WIDTH-1:0] SETTLE_LAST = TIMER_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] OFF_LAST    = TIMER_WIDTH'(OFF_DELAY_CYCLES - 1);

  state_t                 r_state;
  logic [TIMER_WIDTH-1:0] r_timer;
  logic                   r_vm_meta, r_vm_sync;
  logic                   r_vp_meta, r_vp_sync;

  state_t     w_state_next;
  logic [2:0] w_code_next;
  logic       w_ramp_exp, w_settle_exp, w_off_exp, w_fault_wait_done;

  assign w_ramp_exp        = (r_timer == RAMP_LAST);
  assign w_settle_exp      = (r_timer == SETTLE_LAST);
  assign w_off_exp         = (r_timer == OFF_LAST);
  // Timer saturates in FAULT, so once past the delay this stays true.
  assign w_fault_wait_done = (r_timer >= OFF_LAST);

  // Branch order encodes priority: V- fault, V+ fault, timeout, request drop, advance.
  always_comb begin
    w_state_next = r_state;
    w_code_next  = FaultCode;
    case (r_state)
      ST_OFF: begin
        if (PowerRequest && !Fault) w_state_next = ST_NEG_ON;
      end
      ST_NEG_ON: begin
        if (!r_vm_sync && w_ramp_exp) begin
          w_state_next = ST_FAULT;
          w_code_next  = 3'd1;
        end else if (!PowerRequest) w_state_next = ST_NEG_OFF;
        else if (r_vm_sync)         w_state_next = ST_NEG_SETTLE;
      end
      ST_NEG_SETTLE: begin
        if (!r_vm_sync) begin
          w_state_next = ST_FAULT;
          w_code_next  = 3'd3;
        end else if (!PowerRequest) w_state_next = ST_NEG_OFF;
        else if (w_settle_exp)      w_state_next = ST_POS_ON;
      end
      ST_POS_ON: begin
        if (!r_vm_sync) begin
          w_state_next = ST_FAULT;
          w_code_next  = 3'd3;
        end else if (!r_vp_sync && w_ramp_exp) begin
          w_state_next = ST_FAULT;
          w_code_next  = 3'd2;
        end else if (!PowerRequest) w_state_next = ST_POS_OFF;
        else if (r_vp_sync)         w_state_next = ST_ON;
      end
      ST_ON: begin
        if (!r_vm_sync) begin
          w_state_next = ST_FAULT;
          w_code_next  = 3'd3;
        end else if (!r_vp_sync) begin
          w_state_next = ST_FAULT;
          w_code_next  = 3'd4;
        end else if (!PowerRequest) w_state_next = ST_POS_OFF;
      end
      ST_POS_OFF: begin
        if (w_off_exp) w_state_next = ST_NEG_OFF;
      end
      ST_NEG_OFF: begin
        if (w_off_exp) w_state_next = ST_OFF;
      end
      ST_FAULT: begin
        if (w_fault_wait_done && FaultClear && !PowerRequest) begin
          w_state_next = ST_OFF;
          w_code_next  = 3'd0;
        end
      end
      default: w_state_next = ST_OFF;
    endcase
  end

  always_ff @(posedge Clock100Mhz) begin
    if (!ResetN) begin
      r_state      <= ST_OFF;
      r_timer      <= '0;
      r_vm_meta    <= 1'b0;
      r_vm_sync    <= 1'b0;
      r_vp_meta    <= 1'b0;
      r_vp_sync    <= 1'b0;
      EnableVminus <= 1'b0;
      EnableVplus  <= 1'b0;
      LnaReady     <= 1'b0;
      Fault        <= 1'b0;
      FaultCode    <= 3'd0;
      SeqState     <= 3'd0;
    end else begin
      r_vm_meta <= VminusGood;
      r_vm_sync <= r_vm_meta;
      r_vp_meta <= VplusGood;
      r_vp_sync <= r_vp_meta;

      r_state <= w_state_next;
      if (w_state_next != r_state) r_timer <= '0;
      else if (r_timer != '1)      r_timer <= r_timer + TIMER_WIDTH'(1);

      SeqState  <= w_state_next;
      FaultCode <= w_code_next;

      // Outputs decode the state being entered on this edge.
      EnableVminus <= 1'b0;
      EnableVplus  <= 1'b0;
      LnaReady     <= 1'b0;
      Fault        <= 1'b0;
      case (w_state_next)
        ST_NEG_ON, ST_NEG_SETTLE, ST_POS_OFF: EnableVminus <= 1'b1;
        ST_POS_ON: begin
          EnableVminus <= 1'b1;
          EnableVplus  <= 1'b1;
        end
        ST_ON: begin
          EnableVminus <= 1'b1;
          EnableVplus  <= 1'b1;
          LnaReady     <= 1'b1;
        end
        ST_FAULT: begin
          Fault        <= 1'b1;
          // Gate stays biased while the drain discharges, then drops.
          EnableVminus <= (r_state != ST_FAULT) || !w_fault_wait_done;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lna_bias_sequencer.sv
// Directed bench for lna_bias_sequencer with shortened timing parameters
// (ramp 20, settle 8, off delay 4).
module tb_lna_bias_sequencer;

  localparam int RT = 20;
  localparam int SC = 8;
  localparam int OD = 4;

  logic       clk = 1'b0;
  logic       ResetN = 1'b0;
  logic       PowerRequest = 1'b0;
  logic       FaultClear = 1'b0;
  logic       VminusGood = 1'b0;
  logic       VplusGood = 1'b0;
  logic       EnableVminus, EnableVplus, LnaReady, Fault;
  logic [2:0] FaultCode, SeqState;

  int   errors = 0;
  int   checks = 0;
  int   cnt;
  logic vp_seen = 1'b0;

  always #5 clk = ~clk;

  lna_bias_sequencer #(
    .TIMER_WIDTH(20), .RAMP_TIMEOUT(RT), .SETTLE_CYCLES(SC), .OFF_DELAY_CYCLES(OD)
  ) dut (
    .Clock100Mhz (clk),
    .ResetN      (ResetN),
    .PowerRequest(PowerRequest),
    .FaultClear  (FaultClear),
    .VminusGood  (VminusGood),
    .VplusGood   (VplusGood),
    .EnableVminus(EnableVminus),
    .EnableVplus (EnableVplus),
    .LnaReady    (LnaReady),
    .Fault       (Fault),
    .FaultCode   (FaultCode),
    .SeqState    (SeqState)
  );

  // Advance n edges; leaves time 1 ns after the last rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (EnableVplus) vp_seen = 1'b1;
    end
  endtask

  // Step until SeqState == s or the budget runs out; cycles == budget on timeout.
  task automatic wait_state(input logic [2:0] s, input int budget, output int cycles);
    cycles = 0;
    while (SeqState !== s && cycles < budget) begin
      step(1);
      cycles++;
    end
  endtask

  task automatic test_reset();
    ResetN = 1'b0;
    step(3);
    checks++;
    if ({EnableVminus, EnableVplus, LnaReady, Fault, FaultCode, SeqState} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: vm=%0b vp=%0b rdy=%0b flt=%0b code=%0d st=%0d expected all 0",
               EnableVminus, EnableVplus, LnaReady, Fault, FaultCode, SeqState);
    end
    ResetN = 1'b1;
    step(2);
    checks++;
    if (SeqState !== 3'd0) begin
      errors++;
      $display("FAIL reset_idle: SeqState=%0d expected 0", SeqState);
    end
    $display("test_reset done");
  endtask

  task automatic test_normal();
    PowerRequest = 1'b1;
    step(1);
    checks++;
    if (SeqState !== 3'd1 || {EnableVminus, EnableVplus} !== 2'b10) begin
      errors++;
      $display("FAIL normal_neg_on: st=%0d vm=%0b vp=%0b expected st=1 vm=1 vp=0",
               SeqState, EnableVminus, EnableVplus);
    end
    step(4);
    VminusGood = 1'b1;
    wait_state(3'd2, 10, cnt);
    checks++;
    if (cnt !== 3) begin
      errors++;
      $display("FAIL normal_vm_sync_latency: cycles=%0d expected 3", cnt);
    end
    wait_state(3'd3, 20, cnt);
    checks++;
    if (cnt !== SC) begin
      errors++;
      $display("FAIL normal_settle: cycles=%0d expected %0d", cnt, SC);
    end
    checks++;
    if ({EnableVminus, EnableVplus, LnaReady} !== 3'b110) begin
      errors++;
      $display("FAIL normal_pos_on_outputs: vm=%0b vp=%0b rdy=%0b expected 1 1 0",
               EnableVminus, EnableVplus, LnaReady);
    end
    step(2);
    VplusGood = 1'b1;
    wait_state(3'd4, 10, cnt);
    checks++;
    if (cnt !== 3 || LnaReady !== 1'b1) begin
      errors++;
      $display("FAIL normal_on: cycles=%0d rdy=%0b expected cycles=3 rdy=1", cnt, LnaReady);
    end
    PowerRequest = 1'b0;
    step(1);
    checks++;
    if (SeqState !== 3'd5 || {EnableVminus, EnableVplus, LnaReady} !== 3'b100) begin
      errors++;
      $display("FAIL normal_pos_off: st=%0d vm=%0b vp=%0b rdy=%0b expected st=5 1 0 0",
               SeqState, EnableVminus, EnableVplus, LnaReady);
    end
    wait_state(3'd6, 10, cnt);
    checks++;
    if (cnt !== OD || {EnableVminus, EnableVplus} !== 2'b00) begin
      errors++;
      $display("FAIL normal_neg_off: cycles=%0d vm=%0b vp=%0b expected cycles=%0d 0 0",
               cnt, EnableVminus, EnableVplus, OD);
    end
    wait_state(3'd0, 10, cnt);
    checks++;
    if (cnt !== OD) begin
      errors++;
      $display("FAIL normal_off: cycles=%0d expected %0d", cnt, OD);
    end
    VminusGood = 1'b0;
    VplusGood  = 1'b0;
    step(3);
    $display("test_normal done");
  endtask

  task automatic test_vminus_timeout();
    vp_seen = 1'b0;
    PowerRequest = 1'b1;
    step(1);
    wait_state(3'd7, 40, cnt);
    checks++;
    if (cnt !== RT || FaultCode !== 3'd1 || Fault !== 1'b1) begin
      errors++;
      $display("FAIL vm_timeout: cycles=%0d code=%0d flt=%0b expected cycles=%0d code=1 flt=1",
               cnt, FaultCode, Fault, RT);
    end
    step(3);
    checks++;
    if (EnableVminus !== 1'b1) begin
      errors++;
      $display("FAIL vm_timeout_hold: vm=%0b expected 1", EnableVminus);
    end
    step(1);
    checks++;
    if (EnableVminus !== 1'b0 || vp_seen !== 1'b0) begin
      errors++;
      $display("FAIL vm_timeout_release: vm=%0b vp_seen=%0b expected 0 0", EnableVminus, vp_seen);
    end
    FaultClear = 1'b1;
    step(1);
    FaultClear = 1'b0;
    checks++;
    if (SeqState !== 3'd7 || Fault !== 1'b1) begin
      errors++;
      $display("FAIL clear_with_request: st=%0d flt=%0b expected st=7 flt=1", SeqState, Fault);
    end
    PowerRequest = 1'b0;
    FaultClear   = 1'b1;
    step(1);
    FaultClear = 1'b0;
    checks++;
    if (SeqState !== 3'd0 || Fault !== 1'b0 || FaultCode !== 3'd0) begin
      errors++;
      $display("FAIL clear_accepted: st=%0d flt=%0b code=%0d expected 0 0 0", SeqState, Fault, FaultCode);
    end
    $display("test_vminus_timeout done");
  endtask

  task automatic test_vplus_timeout();
    PowerRequest = 1'b1;
    VminusGood   = 1'b1;
    wait_state(3'd3, 40, cnt);
    checks++;
    if (SeqState !== 3'd3) begin
      errors++;
      $display("FAIL vp_reach_pos_on: st=%0d expected 3", SeqState);
    end
    wait_state(3'd7, 40, cnt);
    checks++;
    if (cnt !== RT || FaultCode !== 3'd2 || {EnableVminus, EnableVplus} !== 2'b10) begin
      errors++;
      $display("FAIL vp_timeout: cycles=%0d code=%0d vm=%0b vp=%0b expected cycles=%0d code=2 1 0",
               cnt, FaultCode, EnableVminus, EnableVplus, RT);
    end
    PowerRequest = 1'b0;
    FaultClear   = 1'b1;
    step(1);
    FaultClear = 1'b0;
    checks++;
    if (SeqState !== 3'd7 || FaultCode !== 3'd2) begin
      errors++;
      $display("FAIL clear_too_early: st=%0d code=%0d expected st=7 code=2", SeqState, FaultCode);
    end
    step(2);
    checks++;
    if (EnableVminus !== 1'b1) begin
      errors++;
      $display("FAIL vp_fault_gate_hold: vm=%0b expected 1", EnableVminus);
    end
    step(1);
    checks++;
    if (EnableVminus !== 1'b0 || SeqState !== 3'd7) begin
      errors++;
      $display("FAIL vp_fault_gate_release: vm=%0b st=%0d expected vm=0 st=7", EnableVminus, SeqState);
    end
    FaultClear = 1'b1;
    step(1);
    FaultClear = 1'b0;
    checks++;
    if (SeqState !== 3'd0 || Fault !== 1'b0 || FaultCode !== 3'd0) begin
      errors++;
      $display("FAIL vp_clear: st=%0d flt=%0b code=%0d expected 0 0 0", SeqState, Fault, FaultCode);
    end
    VminusGood = 1'b0;
    step(3);
    $display("test_vplus_timeout done");
  endtask

  task automatic test_rail_loss();
    for (int pass = 0; pass < 2; pass++) begin
      PowerRequest = 1'b1;
      VminusGood   = 1'b1;
      VplusGood    = 1'b1;
      wait_state(3'd4, 40, cnt);
      checks++;
      if (SeqState !== 3'd4) begin
        errors++;
        $display("FAIL loss_reach_on%0d: st=%0d expected 4", pass, SeqState);
      end
      VplusGood = 1'b0;
      if (pass == 1) VminusGood = 1'b0;
      wait_state(3'd7, 6, cnt);
      checks++;
      if (cnt !== 3 || FaultCode !== ((pass == 1) ? 3'd3 : 3'd4) || LnaReady !== 1'b0) begin
        errors++;
        $display("FAIL rail_loss%0d: cycles=%0d code=%0d rdy=%0b expected cycles=3 code=%0d rdy=0",
                 pass, cnt, FaultCode, LnaReady, (pass == 1) ? 3 : 4);
      end
      PowerRequest = 1'b0;
      step(OD);
      FaultClear = 1'b1;
      step(1);
      FaultClear = 1'b0;
      checks++;
      if (SeqState !== 3'd0 || FaultCode !== 3'd0) begin
        errors++;
        $display("FAIL loss_clear%0d: st=%0d code=%0d expected 0 0", pass, SeqState, FaultCode);
      end
    end
    VminusGood = 1'b0;
    VplusGood  = 1'b0;
    step(3);
    $display("test_rail_loss done");
  endtask

  task automatic test_abort_reset();
    PowerRequest = 1'b1;
    VminusGood   = 1'b1;
    wait_state(3'd3, 40, cnt);
    PowerRequest = 1'b0;
    step(1);
    checks++;
    if (SeqState !== 3'd5 || {EnableVminus, EnableVplus} !== 2'b10) begin
      errors++;
      $display("FAIL abort_pos_off: st=%0d vm=%0b vp=%0b expected st=5 1 0", SeqState, EnableVminus, EnableVplus);
    end
    PowerRequest = 1'b1;
    wait_state(3'd6, 10, cnt);
    checks++;
    if (cnt !== OD) begin
      errors++;
      $display("FAIL abort_neg_off: cycles=%0d expected %0d", cnt, OD);
    end
    wait_state(3'd0, 10, cnt);
    checks++;
    if (cnt !== OD) begin
      errors++;
      $display("FAIL abort_off: cycles=%0d expected %0d", cnt, OD);
    end
    step(1);
    checks++;
    if (SeqState !== 3'd1) begin
      errors++;
      $display("FAIL abort_restart: st=%0d expected 1", SeqState);
    end
    VplusGood = 1'b1;
    wait_state(3'd4, 40, cnt);
    ResetN = 1'b0;
    step(1);
    checks++;
    if ({EnableVminus, EnableVplus, LnaReady} !== 3'b000 || SeqState !== 3'd0) begin
      errors++;
      $display("FAIL reset_in_on: vm=%0b vp=%0b rdy=%0b st=%0d expected 0 0 0 0",
               EnableVminus, EnableVplus, LnaReady, SeqState);
    end
    ResetN       = 1'b1;
    PowerRequest = 1'b0;
    step(2);
    $display("test_abort_reset done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal();
    test_vminus_timeout();
    test_vplus_timeout();
    test_rail_loss();
    test_abort_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
